// File: rtl/id_stage_reg.sv
// ID/EX pipeline register: latches decode outputs, applies reset/freeze/flush/bubble/cond-fail
// priority, and keeps saturating bubble and flush counters for performance debug.
module id_stage_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        hazard,
    input  logic        cond_pass,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic [3:0]  EX_command_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        WB_en_in,
    input  logic        B_in,
    input  logic        S_in,
    input  logic        imm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  src1_in,
    input  logic [3:0]  src2_in,
    input  logic        carry_in,
    output logic [31:0] pc_out,
    output logic [31:0] val_rn_out,
    output logic [31:0] val_rm_out,
    output logic [3:0]  EX_command_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        WB_en_out,
    output logic        B_out,
    output logic        S_out,
    output logic        imm_out,
    output logic [11:0] shift_operand_out,
    output logic [23:0] signed_imm_24_out,
    output logic [3:0]  dest_out,
    output logic [3:0]  src1_out,
    output logic [3:0]  src2_out,
    output logic        carry_out,
    output logic        valid_out,
    output logic [15:0] bubble_count,
    output logic [15:0] flush_count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [3:0]  ex_cmd;
        logic        mem_read;
        logic        mem_write;
        logic        wb_en;
        logic        b;
        logic        s;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        carry;
    } id_ex_t;

    id_ex_t      w_load;
    id_ex_t      r_q;
    logic        r_valid;
    logic [15:0] r_bubble_cnt;
    logic [15:0] r_flush_cnt;

    // A failed condition keeps the instruction in flight but strips every side effect.
    always_comb begin
        w_load               = '0;
        w_load.pc            = pc_in;
        w_load.val_rn        = val_rn_in;
        w_load.val_rm        = val_rm_in;
        w_load.ex_cmd        = EX_command_in;
        w_load.mem_read      = mem_read_in  & cond_pass;
        w_load.mem_write     = mem_write_in & cond_pass;
        w_load.wb_en         = WB_en_in     & cond_pass;
        w_load.b             = B_in         & cond_pass;
        w_load.s             = S_in         & cond_pass;
        w_load.imm           = imm_in;
        w_load.shift_operand = shift_operand_in;
        w_load.signed_imm_24 = signed_imm_24_in;
        w_load.dest          = dest_in;
        w_load.src1          = src1_in;
        w_load.src2          = src2_in;
        w_load.carry         = carry_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q          <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (!freeze) begin
            if (flush) begin
                r_q     <= '0;
                r_valid <= 1'b0;
                if (r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
            end else if (hazard) begin
                r_q     <= '0;
                r_valid <= 1'b0;
                if (r_bubble_cnt != 16'hFFFF) r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end else begin
                r_q     <= w_load;
                r_valid <= 1'b1;
            end
        end
    end

    assign pc_out            = r_q.pc;
    assign val_rn_out        = r_q.val_rn;
    assign val_rm_out        = r_q.val_rm;
    assign EX_command_out    = r_q.ex_cmd;
    assign mem_read_out      = r_q.mem_read;
    assign mem_write_out     = r_q.mem_write;
    assign WB_en_out         = r_q.wb_en;
    assign B_out             = r_q.b;
    assign S_out             = r_q.s;
    assign imm_out           = r_q.imm;
    assign shift_operand_out = r_q.shift_operand;
    assign signed_imm_24_out = r_q.signed_imm_24;
    assign dest_out          = r_q.dest;
    assign src1_out          = r_q.src1;
    assign src2_out          = r_q.src2;
    assign carry_out         = r_q.carry;
    assign valid_out         = r_valid;
    assign bubble_count      = r_bubble_cnt;
    assign flush_count       = r_flush_cnt;

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed bench for id_stage_reg: reset, streaming, freeze, flush, cond-fail, bubbles, saturation.
module tb_id_stage_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, hazard, cond_pass;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [3:0]  EX_command_in;
    logic        mem_read_in, mem_write_in, WB_en_in, B_in, S_in, imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in, src1_in, src2_in;
    logic        carry_in;

    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [3:0]  EX_command_out;
    logic        mem_read_out, mem_write_out, WB_en_out, B_out, S_out, imm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  dest_out, src1_out, src2_out;
    logic        carry_out, valid_out;
    logic [15:0] bubble_count, flush_count;

    int total = 0;
    int bad   = 0;

    wire [155:0] all_out = {pc_out, val_rn_out, val_rm_out, EX_command_out, mem_read_out,
                            mem_write_out, WB_en_out, B_out, S_out, imm_out, shift_operand_out,
                            signed_imm_24_out, dest_out, src1_out, src2_out, carry_out, valid_out};

    id_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
        .cond_pass(cond_pass), .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .EX_command_in(EX_command_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .WB_en_in(WB_en_in), .B_in(B_in), .S_in(S_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .carry_in(carry_in),
        .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .EX_command_out(EX_command_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .WB_en_out(WB_en_out), .B_out(B_out), .S_out(S_out),
        .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out), .src1_out(src1_out),
        .src2_out(src2_out), .carry_out(carry_out), .valid_out(valid_out),
        .bubble_count(bubble_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_busy();
        pc_in = 32'hA5A5_0004; val_rn_in = 32'h1111_2222; val_rm_in = 32'h3333_4444;
        EX_command_in = 4'hF; mem_read_in = 1'b1; mem_write_in = 1'b1; WB_en_in = 1'b1;
        B_in = 1'b1; S_in = 1'b1; imm_in = 1'b1; shift_operand_in = 12'hABC;
        signed_imm_24_in = 24'h123456; dest_in = 4'h7; src1_in = 4'h8; src2_in = 4'h9;
        carry_in = 1'b1;
    endtask

    task automatic drive_quiet();
        pc_in = '0; val_rn_in = '0; val_rm_in = '0; EX_command_in = '0; mem_read_in = 0;
        mem_write_in = 0; WB_en_in = 0; B_in = 0; S_in = 0; imm_in = 0;
        shift_operand_in = '0; signed_imm_24_in = '0; dest_in = '0; src1_in = '0;
        src2_in = '0; carry_in = 0;
    endtask

    task automatic test_reset();
        rst = 0; freeze = 0; flush = 1; hazard = 1; cond_pass = 1;
        drive_busy();
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (all_out !== 156'd0) begin bad++; $display("FAIL reset_out[%0d]: got %h want 0", i, all_out); end
            total++; if ({bubble_count, flush_count} !== 32'd0) begin bad++; $display("FAIL reset_cnt[%0d]: got %h want 0", i, {bubble_count, flush_count}); end
        end
        rst = 1; flush = 0; hazard = 0;
        drive_quiet(); pc_in = 32'h10; WB_en_in = 1;
        tick();
        total++; if (pc_out !== 32'h10) begin bad++; $display("FAIL reset_release_pc: got %h want 10", pc_out); end
        total++; if (WB_en_out !== 1'b1 || valid_out !== 1'b1) begin bad++; $display("FAIL reset_release_ctl: wb=%b valid=%b want 1 1", WB_en_out, valid_out); end
    endtask

    task automatic test_stream_freeze();
        for (int i = 1; i <= 3; i++) begin
            pc_in = 32'(4 * i);
            tick();
            total++; if (pc_out !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d]: got %0d want %0d", i, pc_out, 4 * i); end
        end
        freeze = 1; pc_in = 32'd16;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pc_out !== 32'd12) begin bad++; $display("FAIL freeze_hold[%0d]: got %0d want 12", i, pc_out); end
        end
        freeze = 0;
        tick();
        total++; if (pc_out !== 32'd16) begin bad++; $display("FAIL freeze_resume: got %0d want 16", pc_out); end
    endtask

    task automatic test_flush();
        drive_busy(); flush = 1;
        tick();
        total++; if (all_out !== 156'd0) begin bad++; $display("FAIL flush_out: got %h want 0", all_out); end
        total++; if (flush_count !== 16'd1) begin bad++; $display("FAIL flush_cnt: got %0d want 1", flush_count); end
        flush = 0; pc_in = 32'd20;
        tick();
        total++; if (pc_out !== 32'd20 || valid_out !== 1'b1) begin bad++; $display("FAIL flush_reload: pc=%0d valid=%b want 20 1", pc_out, valid_out); end
        flush = 1; freeze = 1; pc_in = 32'd24;
        tick();
        total++; if (pc_out !== 32'd20 || valid_out !== 1'b1 || WB_en_out !== 1'b1) begin bad++; $display("FAIL flush_frozen_out: pc=%0d valid=%b wb=%b want 20 1 1", pc_out, valid_out, WB_en_out); end
        total++; if (flush_count !== 16'd1) begin bad++; $display("FAIL flush_frozen_cnt: got %0d want 1", flush_count); end
        freeze = 0; hazard = 1;
        tick();
        total++; if (flush_count !== 16'd2 || bubble_count !== 16'd0) begin bad++; $display("FAIL flush_hazard_cnt: flush=%0d bubble=%0d want 2 0", flush_count, bubble_count); end
        total++; if (all_out !== 156'd0) begin bad++; $display("FAIL flush_hazard_out: got %h want 0", all_out); end
        flush = 0; hazard = 0;
    endtask

    task automatic test_cond_fail();
        drive_quiet(); cond_pass = 0;
        WB_en_in = 1; mem_write_in = 1; mem_read_in = 1; B_in = 1; S_in = 1;
        EX_command_in = 4'b0010; val_rn_in = 32'hDEADBEEF; shift_operand_in = 12'h5A5;
        tick();
        total++; if ({WB_en_out, mem_read_out, mem_write_out, B_out, S_out} !== 5'b0) begin bad++; $display("FAIL cond_ctl: got %b want 00000", {WB_en_out, mem_read_out, mem_write_out, B_out, S_out}); end
        total++; if (EX_command_out !== 4'b0010 || val_rn_out !== 32'hDEADBEEF || shift_operand_out !== 12'h5A5) begin bad++; $display("FAIL cond_data: cmd=%b rn=%h sh=%h want 0010 deadbeef 5a5", EX_command_out, val_rn_out, shift_operand_out); end
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL cond_valid: got %b want 1", valid_out); end
        cond_pass = 1;
        tick();
        total++; if ({WB_en_out, mem_write_out, S_out} !== 3'b111) begin bad++; $display("FAIL cond_pass_ctl: got %b want 111", {WB_en_out, mem_write_out, S_out}); end
    endtask

    task automatic test_hazard();
        drive_busy(); hazard = 1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            total++; if (all_out !== 156'd0) begin bad++; $display("FAIL bubble_out[%0d]: got %h want 0", i, all_out); end
            total++; if (bubble_count !== 16'(i)) begin bad++; $display("FAIL bubble_cnt[%0d]: got %0d want %0d", i, bubble_count, i); end
        end
        hazard = 0; pc_in = 32'd44;
        tick();
        total++; if (pc_out !== 32'd44 || valid_out !== 1'b1 || dest_out !== 4'h7) begin bad++; $display("FAIL bubble_resume: pc=%0d valid=%b dest=%h want 44 1 7", pc_out, valid_out, dest_out); end
        total++; if (bubble_count !== 16'd2 || flush_count !== 16'd2) begin bad++; $display("FAIL bubble_resume_cnt: b=%0d f=%0d want 2 2", bubble_count, flush_count); end
    endtask

    task automatic test_reset_frozen();
        rst = 0; freeze = 1; flush = 1;
        tick();
        total++; if (all_out !== 156'd0 || {bubble_count, flush_count} !== 32'd0) begin bad++; $display("FAIL reset_frozen: out=%h cnt=%h want 0 0", all_out, {bubble_count, flush_count}); end
        rst = 1; freeze = 0; flush = 0;
    endtask

    task automatic test_saturation();
        hazard = 1;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        total++; if (bubble_count !== 16'hFFFE) begin bad++; $display("FAIL sat_pre: got %h want fffe", bubble_count); end
        tick();
        total++; if (bubble_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hit: got %h want ffff", bubble_count); end
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        total++; if (bubble_count !== 16'hFFFF || flush_count !== 16'd0) begin bad++; $display("FAIL sat_hold: b=%h f=%h want ffff 0", bubble_count, flush_count); end
        rst = 0;
        tick();
        total++; if (bubble_count !== 16'd0) begin bad++; $display("FAIL sat_reset: got %h want 0", bubble_count); end
        rst = 1; hazard = 0;
    endtask

    initial begin
        rst = 0; freeze = 0; flush = 0; hazard = 0; cond_pass = 1;
        drive_quiet();
        #1;
        test_reset();
        test_stream_freeze();
        test_flush();
        test_cond_fail();
        test_hazard();
        test_reset_frozen();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
